// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the 9-bit processor sequencer: opcode classes, state enum and
// the strobe bundle issued to the datapath.
package instr_sequencer_pkg;

   localparam int unsigned InstrW = 9;
   localparam int unsigned OpW    = 3;
   localparam int unsigned OffW   = 6;
   localparam int unsigned CntW   = 16;
   localparam int unsigned TmoW   = 8;

   // Opcode classes in ir[8:6]; 3'b00x is R-type
   localparam logic [OpW-1:0] kST   = 3'b010;
   localparam logic [OpW-1:0] kLD   = 3'b011;
   localparam logic [OpW-1:0] kJ    = 3'b100;
   localparam logic [OpW-1:0] kCMP  = 3'b101;
   localparam logic [OpW-1:0] kBRE  = 3'b110;
   localparam logic [OpW-1:0] kHALT = 3'b111;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      EXEC,
      MEM,
      WB,
      HALT
   } seq_state_t;

   typedef struct packed {
      logic alu_en;
      logic mem_req;
      logic mem_we;
      logic rf_we;
      logic done;
   } strobe_t;

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction ROM and data-memory handshake bus between the sequencer and its memories.
interface instr_sequencer_if
   import instr_sequencer_pkg::*;
#(
   parameter int unsigned PcW = 10
) ();

   logic [PcW-1:0]    prog_ctr;
   logic [InstrW-1:0] instr;
   logic              mem_req;
   logic              mem_we;
   logic              mem_ready;

   modport master (
      output prog_ctr,
      output mem_req,
      output mem_we,
      input  instr,
      input  mem_ready
   );

   modport slave (
      input  prog_ctr,
      input  mem_req,
      input  mem_we,
      output instr,
      output mem_ready
   );

endinterface

// File: rtl/pc_unit.sv
// Program counter: cleared on (re)start, advanced on retire by +1 or by the
// sign-extended offset when taken; wraps modulo 2^PcW.
module pc_unit
   import instr_sequencer_pkg::*;
#(
   parameter int unsigned PcW = 10
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            clear,
   input  logic            retire,
   input  logic            taken,
   input  logic [OffW-1:0] offset,
   output logic [PcW-1:0]  pc
);

   logic [PcW-1:0] step;
   logic [PcW-1:0] pc_nxt;

   always_comb begin
      step   = taken ? {{(PcW-OffW){offset[OffW-1]}}, offset} : PcW'(1);
      pc_nxt = pc + step;
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         pc <= '0;
      end else if (retire) begin
         pc <= pc_nxt;
      end
   end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle sequencer: steps each instruction through FETCH/DECODE/EXEC/MEM/WB and
// issues registered datapath strobes, with memory timeout and retired-instruction count.
module instr_sequencer
   import instr_sequencer_pkg::*;
#(
   parameter int unsigned PcW        = 10,
   parameter int unsigned MemTimeout = 15
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic                Start,
   input  logic                Zero,
   instr_sequencer_if.master   bus,
   output logic [InstrW-1:0]   ir,
   output logic                alu_en,
   output logic                rf_we,
   output logic                Done,
   output logic                err,
   output logic [CntW-1:0]     instr_cnt
);

   seq_state_t        state;
   seq_state_t        state_nxt;
   logic [InstrW-1:0] ir_nxt;
   logic [TmoW-1:0]   tmo_cnt;
   logic [TmoW-1:0]   tmo_nxt;
   logic              retire;
   logic              taken;
   logic              pc_clear;
   logic              err_set;
   logic              restart;
   strobe_t           strb;
   strobe_t           strb_nxt;
   logic [OpW-1:0]    op;
   logic [OpW-1:0]    op_nxt;
   logic [PcW-1:0]    pc;

   assign op     = ir[InstrW-1 -: OpW];
   assign op_nxt = ir_nxt[InstrW-1 -: OpW];

   pc_unit #(.PcW(PcW)) u_pc_unit (
      .clk    (Clk),
      .reset  (Reset),
      .clear  (pc_clear),
      .retire (retire),
      .taken  (taken),
      .offset (ir[OffW-1:0]),
      .pc     (pc)
   );

   // Next state, retire control and the strobes the next state will present
   always_comb begin
      state_nxt = state;
      ir_nxt    = ir;
      tmo_nxt   = tmo_cnt;
      retire    = 1'b0;
      taken     = 1'b0;
      pc_clear  = 1'b0;
      err_set   = 1'b0;
      restart   = 1'b0;
      strb_nxt  = '0;

      case (state)
         IDLE: begin
            if (Start) begin
               state_nxt = FETCH;
               pc_clear  = 1'b1;
            end
         end
         FETCH: begin
            ir_nxt    = bus.instr;
            state_nxt = DECODE;
         end
         DECODE: begin
            state_nxt = (op == kHALT) ? HALT : EXEC;
         end
         EXEC: begin
            tmo_nxt = '0;
            if (op == kLD || op == kST) begin
               state_nxt = MEM;
            end else if (op == kJ) begin
               state_nxt = FETCH;
               retire    = 1'b1;
               taken     = 1'b1;
            end else if (op == kBRE) begin
               state_nxt = FETCH;
               retire    = 1'b1;
               taken     = Zero;
            end else begin
               state_nxt = WB;
            end
         end
         MEM: begin
            // Ready in the final allowed cycle still completes the access
            if (bus.mem_ready) begin
               if (op == kST) begin
                  state_nxt = FETCH;
                  retire    = 1'b1;
               end else begin
                  state_nxt = WB;
               end
            end else if (tmo_cnt == TmoW'(MemTimeout - 1)) begin
               state_nxt = HALT;
               err_set   = 1'b1;
            end else begin
               tmo_nxt = tmo_cnt + TmoW'(1);
            end
         end
         WB: begin
            state_nxt = FETCH;
            retire    = 1'b1;
         end
         HALT: begin
            if (Start) begin
               state_nxt = FETCH;
               pc_clear  = 1'b1;
               restart   = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      strb_nxt.alu_en  = (state_nxt == EXEC);
      strb_nxt.mem_req = (state_nxt == MEM);
      strb_nxt.mem_we  = (state_nxt == MEM) && (op_nxt == kST);
      strb_nxt.rf_we   = (state_nxt == WB);
      strb_nxt.done    = (state_nxt == HALT);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= IDLE;
         ir        <= '0;
         tmo_cnt   <= '0;
         err       <= 1'b0;
         instr_cnt <= '0;
         strb      <= '0;
      end else begin
         state   <= state_nxt;
         ir      <= ir_nxt;
         tmo_cnt <= tmo_nxt;
         strb    <= strb_nxt;
         if (restart) begin
            err <= 1'b0;
         end else if (err_set) begin
            err <= 1'b1;
         end
         if (restart) begin
            instr_cnt <= '0;
         end else if (retire && (instr_cnt != '1)) begin
            instr_cnt <= instr_cnt + CntW'(1);
         end
      end
   end

   assign bus.prog_ctr = pc;
   assign bus.mem_req  = strb.mem_req;
   assign bus.mem_we   = strb.mem_we;
   assign alu_en       = strb.alu_en;
   assign rf_we        = strb.rf_we;
   assign Done         = strb.done;

endmodule
